// File: rtl/fir_mac_engine.sv
// Single-MAC FIR engine: one accepted sample triggers a full sweep of the coefficient
// ROM against the circular sample history, then one rounded, saturated result.
module fir_mac_engine #(
  parameter int TAPS = 492,
  parameter int DW   = 24,
  parameter int CW   = 24,
  parameter int FRAC = 22,
  parameter int AW   = 9,
  parameter int ACCW = 57
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_data,
  output logic signed [DW-1:0] out_data,
  output logic                 out_valid,
  output logic                 busy
);
  localparam int RW = ACCW - FRAC;
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);
  localparam logic signed [RW-1:0] RMAX = RW'((2**(DW-1)) - 1);
  localparam logic signed [RW-1:0] RMIN = RW'(-(2**(DW-1)));
  localparam logic signed [ACCW-1:0] HALF = ACCW'(1) <<< (FRAC-1);

  typedef enum logic [1:0] {CLEAR, IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [AW-1:0]           k, wr_ptr, rd_ptr;
  logic [2:1]              vld_pipe;
  logic signed [DW-1:0]    hist [TAPS];
  logic signed [DW-1:0]    hist_q;
  logic signed [DW+CW-1:0] prod;
  logic signed [ACCW-1:0]  acc;
  logic signed [RW-1:0]    r;
  logic signed [DW-1:0]    sat;
  logic                    run, accept, drained;

  assign run       = (state == RUN);
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid & in_ready;
  assign drained   = (vld_pipe == '0);
  assign coef_addr = run ? k : '0;

  // round half up, then clamp into the output range
  assign r   = RW'((acc + HALF) >>> FRAC);
  assign sat = (r > RMAX) ? DW'(RMAX) : (r < RMIN) ? DW'(RMIN) : r[DW-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (k == LAST) state_nxt = IDLE;
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (k == LAST) state_nxt = DRAIN;
      DRAIN:   if (drained)   state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      k         <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      vld_pipe  <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      vld_pipe  <= {vld_pipe[1], run};
      out_valid <= 1'b0;
      if (vld_pipe[2]) acc <= acc + ACCW'(prod);
      case (state)
        CLEAR: k <= (k == LAST) ? '0 : k + 1'b1;
        IDLE: if (in_valid) begin
          wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
          rd_ptr <= wr_ptr;
          acc    <= '0;
          k      <= '0;
        end
        RUN: begin
          k      <= (k == LAST) ? '0 : k + 1'b1;
          // walk back through history: x[n-k], wrapping below zero
          rd_ptr <= (rd_ptr == '0) ? LAST : rd_ptr - 1'b1;
        end
        DRAIN: if (drained) begin
          out_data  <= sat;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // history RAM and datapath stages carry no reset; vld_pipe qualifies them
  always_ff @(posedge clk) begin
    if (state == CLEAR) hist[k] <= '0;
    else if (accept)    hist[wr_ptr] <= in_data;
    hist_q <= hist[rd_ptr];
    prod   <= hist_q * coef_data;
  end
endmodule

// File: tb/tb_fir_mac_engine.sv
// Randomized bench for fir_mac_engine: a convolution model over the accepted-sample list
// predicts every result and its timing; literal impulse responses pin the model.
module tb_fir_mac_engine;
  localparam int TAPS = 492, DW = 24, CW = 24, FRAC = 22, AW = 9, ACCW = 57;
  localparam int LAT  = TAPS + 3;
  localparam longint MAXV = 8388607, MINV = -8388608;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data = '0;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic                 busy;

  int     coef [TAPS];
  int     xh [$];
  longint exp_q [$];
  int     due_q [$];
  longint got [$];
  int     pe, ready_from, cur_a;
  longint last_exp;
  int     checks = 0, errors = 0;

  fir_mac_engine #(.TAPS(TAPS), .DW(DW), .CW(CW), .FRAC(FRAC), .AW(AW), .ACCW(ACCW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .coef_addr(coef_addr), .coef_data(coef_data), .out_data(out_data),
    .out_valid(out_valid), .busy(busy));

  initial forever #5 clk = ~clk;

  // coefficient ROM, one clock of read latency
  always @(posedge clk)
    coef_data <= (coef_addr < AW'(TAPS)) ? CW'(coef[coef_addr]) : '0;

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // y[n] = sum c[k]*x[n-k], rounded half up at FRAC bits and clamped
  function automatic longint model_out();
    longint s = 0;
    int n = xh.size() - 1;
    for (int i = 0; i < TAPS && i <= n; i++) s += longint'(coef[i]) * longint'(xh[n-i]);
    s = (s + (longint'(1) <<< (FRAC-1))) >>> FRAC;
    if (s > MAXV) s = MAXV;
    if (s < MINV) s = MINV;
    return s;
  endfunction

  // model: timing bookkeeping per rising edge
  initial forever begin
    @(posedge clk);
    if (rst) begin
      pe = 0; ready_from = TAPS; cur_a = -1;
      xh.delete(); exp_q.delete(); due_q.delete();
    end else begin
      if (in_valid && pe >= ready_from) begin
        cur_a = pe + 1;
        xh.push_back(int'(in_data));
        exp_q.push_back(model_out());
        due_q.push_back(cur_a + LAT);
        ready_from = cur_a + LAT;
      end
      pe++;
    end
  end

  // compare: every cycle, away from the active edge
  initial forever begin : cmp
    bit rdy, ov;
    longint ca, ed;
    @(negedge clk);
    if (rst) begin
      last_exp = 0;
      chk("rst_in_ready", longint'(in_ready), 0);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_data", longint'(out_data), 0);
      chk("rst_coef_addr", longint'(coef_addr), 0);
      chk("rst_busy", longint'(busy), 1);
    end else begin
      rdy = (pe >= ready_from);
      ov  = (due_q.size() > 0) && (due_q[0] == pe);
      ca  = (cur_a >= 0 && pe - cur_a >= 0 && pe - cur_a < TAPS) ? longint'(pe - cur_a) : 0;
      ed  = ov ? exp_q[0] : last_exp;
      chk("in_ready", longint'(in_ready), longint'(rdy));
      chk("busy", longint'(busy), longint'(!rdy));
      chk("out_valid", longint'(out_valid), longint'(ov));
      chk("out_data", longint'(out_data), ed);
      chk("coef_addr", longint'(coef_addr), ca);
      if (ov) begin
        got.push_back(longint'(out_data));
        last_exp = ed;
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
    end
  end

  task automatic send(input int x);
    int n = 0;
    while (pe < ready_from && n < 2000) begin @(negedge clk); #1; n++; end
    if (n >= 2000) chk("send_timeout", 1, 0);
    in_valid = 1'b1; in_data = DW'(x);
    @(negedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (due_q.size() > 0 && n < 1200) begin @(negedge clk); #1; n++; end
    chk("drain_timeout", longint'(due_q.size()), 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    got.delete();
  endtask

  task automatic pin(input string nm, input int idx, input longint expv);
    if (got.size() <= idx) chk({nm, "_missing"}, longint'(got.size()), longint'(idx + 1));
    else chk(nm, got[idx], expv);
  endtask

  initial begin
    for (int i = 0; i < TAPS / 2; i++) coef[i] = int'($urandom_range(6000)) - 3000;
    coef[0] = 663; coef[1] = 215; coef[2] = 194; coef[3] = 130;
    coef[6] = 2500000; coef[8] = 3000000;
    coef[234] = -902362; coef[245] = 4160060;
    for (int i = 0; i < TAPS / 2; i++) coef[TAPS-1-i] = coef[i];
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // impulse response after CLEAR
    send(4194304);
    repeat (7) send(0);
    wait_drain();
    pin("imp_y0", 0, 663); pin("imp_y1", 1, 215);
    pin("imp_y2", 2, 194); pin("imp_y3", 3, 130);

    // in_valid held high: only IDLE-cycle samples are taken
    got.delete();
    for (int i = 0; i < 4 * (LAT + 1) + 4; i++) begin
      in_valid = 1'b1; in_data = DW'($urandom);
      @(negedge clk); #1;
    end
    in_valid = 1'b0;
    wait_drain();
    chk("cont_outputs", longint'(got.size()), 5);

    // saturation both ways
    got.delete();
    repeat (12) send(8388607);
    wait_drain();
    pin("sat_pos", 11, MAXV);
    got.delete();
    repeat (12) send(-8388608);
    wait_drain();
    pin("sat_neg", 11, MINV);

    // random samples, small and full range
    repeat (20) send(($urandom_range(3) == 0) ? int'($urandom_range(2000)) - 1000
                                              : int'($urandom) >>> 8);
    wait_drain();

    // abort mid-computation at tap 200
    send(123456);
    repeat (200) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_out_valid", longint'(out_valid), 0);
    chk("abort_out_data", longint'(out_data), 0);
    chk("abort_coef_addr", longint'(coef_addr), 0);
    chk("abort_in_ready", longint'(in_ready), 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    got.delete();
    send(4194304);
    repeat (3) send(0);
    wait_drain();
    pin("post_rst_y0", 0, 663); pin("post_rst_y1", 1, 215);
    pin("post_rst_y2", 2, 194); pin("post_rst_y3", 3, 130);

    // rounding: exact halves round up, small impulse rounds to zero
    do_reset();
    send(2097152);
    repeat (3) send(0);
    wait_drain();
    pin("half_y0", 0, 332); pin("half_y1", 1, 108);
    pin("half_y2", 2, 97);  pin("half_y3", 3, 65);
    do_reset();
    send(-2097152);
    send(0);
    wait_drain();
    pin("nhalf_y0", 0, -331); pin("nhalf_y1", 1, -107);
    do_reset();
    send(1);
    send(0);
    wait_drain();
    pin("unit_y0", 0, 0); pin("unit_y1", 1, 0);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
